// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial bit-pattern detector with a
// registered one-cycle match pulse. An N-bit history window is compared
// against a loadable pattern. A fill counter ensures that no match is
// reported until N valid bits have arrived since reset, a configuration
// load or a non-overlapping match.
// Optional feature: define SEQDET_COUNT_EN to add the match_count port and
// its CNT_W-bit saturating match counter.
module seq_detect_prog #(
  parameter int unsigned    N               = 4,
  parameter logic [N-1:0]   DEFAULT_PATTERN = 4'b1011,
  parameter logic           DEFAULT_OVERLAP = 1'b1,
  parameter int unsigned    CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             data,
  input  logic             cfg_load,
  input  logic [N-1:0]     cfg_pattern,
  input  logic             cfg_overlap,
  output logic             detected
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_count
`endif
);

  localparam int unsigned   FW        = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);

  logic [N-1:0]  pattern_q, pattern_d;
  logic          overlap_q, overlap_d;
  logic [N-1:0]  hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          det_q, det_d;

  logic [N-1:0]  hist_n;
  logic [FW-1:0] fill_n;
  logic          match;

  // Window update candidates and match decision for the current input bit
  always_comb begin
    hist_n = {hist_q[N-2:0], data};
    fill_n = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    match  = (fill_n == FILL_FULL) && (hist_n == pattern_q);
  end

  // Next-state selection: configuration load, then sample step, else hold
  always_comb begin
    pattern_d = pattern_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    det_d     = 1'b0;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (in_valid) begin
      det_d = match;
      if (match && !overlap_q) begin
        // Non-overlapping: the next match must be built from N fresh bits.
        hist_d = '0;
        fill_d = '0;
      end else begin
        // On an overlapping match fill_n is already saturated at N.
        hist_d = hist_n;
        fill_d = fill_n;
      end
    end
  end

  // State registers with synchronous reset to the default configuration
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= DEFAULT_PATTERN;
      overlap_q <= DEFAULT_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      det_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      det_q     <= det_d;
    end
  end

  assign detected = det_q;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating match counter, cleared by a configuration load
  always_comb begin
    cnt_d = cnt_q;
    if (cfg_load) begin
      cnt_d = '0;
    end else if (in_valid && match && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register, updated on the same edge that sets detected
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Testbench for seq_detect_prog. The reference model stores the valid bits
// received since the last restart in a queue and compares the newest N of
// them against the pattern as an integer value.
module tb_seq_detect_prog;

  localparam int unsigned N     = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             data;
  logic             cfg_load;
  logic [N-1:0]     cfg_pattern;
  logic             cfg_overlap;
  logic             detected;
`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] match_count;
`endif

  seq_detect_prog #(
    .N              (N),
    .DEFAULT_PATTERN(4'b1011),
    .DEFAULT_OVERLAP(1'b1),
    .CNT_W          (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .data       (data),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap),
    .detected   (detected)
`ifdef SEQDET_COUNT_EN
    ,
    .match_count(match_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Reference model state
  int unsigned m_pat;
  bit          m_ovl;
  bit          m_win[$];
  int unsigned m_cnt;
  bit          exp_det;

  function automatic void model_restart();
    m_win.delete();
    m_cnt   = 0;
    exp_det = 1'b0;
  endfunction

  function automatic void model_sample(input bit d);
    int unsigned val;
    m_win.push_back(d);
    if (m_win.size() > N) void'(m_win.pop_front());
    exp_det = 1'b0;
    if (m_win.size() == N) begin
      val = 0;
      foreach (m_win[i]) val = val * 2 + m_win[i];
      if (val == m_pat) begin
        exp_det = 1'b1;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!m_ovl) m_win.delete();
      end
    end
  endfunction

  task automatic check(input string tag);
    vectors++;
    assert (detected === exp_det)
    else begin
      miscompares++;
      $error("FAIL %s detected: observed %b expected %b", tag, detected, exp_det);
    end
`ifdef SEQDET_COUNT_EN
    vectors++;
    assert (match_count === CNT_W'(m_cnt))
    else begin
      miscompares++;
      $error("FAIL %s match_count: observed %0d expected %0d", tag, match_count, m_cnt);
    end
`endif
  endtask

  task automatic clock_and_check(input string tag);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic step(input bit v, input bit d, input string tag);
    rst = 1'b0; cfg_load = 1'b0; in_valid = v; data = d;
    cfg_pattern = N'($urandom); cfg_overlap = 1'($urandom);
    if (v) model_sample(d);
    else exp_det = 1'b0;
    clock_and_check(tag);
  endtask

  task automatic send(input bit [31:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], tag);
  endtask

  // Reset; in_valid and cfg_load are driven randomly to show rst priority
  task automatic do_rst(input string tag);
    rst = 1'b1; cfg_load = 1'($urandom); in_valid = 1'($urandom); data = 1'($urandom);
    cfg_pattern = N'($urandom); cfg_overlap = 1'($urandom);
    m_pat = 4'b1011; m_ovl = 1'b1;
    model_restart();
    clock_and_check(tag);
  endtask

  // Configuration load; a concurrent valid bit must be dropped
  task automatic do_cfg(input bit [N-1:0] pat, input bit ovl, input string tag);
    rst = 1'b0; cfg_load = 1'b1; in_valid = 1'($urandom); data = 1'($urandom);
    cfg_pattern = pat; cfg_overlap = ovl;
    m_pat = pat; m_ovl = ovl;
    model_restart();
    clock_and_check(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; data = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_overlap = 1'b0;

    do_rst("reset");
    do_rst("reset2");

    // Default pattern 1011, overlapping: pulses after bits 4 and 7
    send(32'b1011011, 7, "default_ovl");

    do_cfg(4'b1011, 1'b0, "cfg_nonovl");
    send(32'b1011011, 7, "nonovl");

    do_cfg(4'b1111, 1'b1, "cfg_ones_ovl");
    send(32'b1111111, 7, "ones_ovl");
    do_cfg(4'b1111, 1'b0, "cfg_ones_nonovl");
    send(32'b1111111, 7, "ones_nonovl");

    // Gap of three idle cycles between bits 2 and 3
    do_cfg(4'b1011, 1'b1, "cfg_gap");
    send(32'b10, 2, "gap_head");
    for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom), "gap_idle");
    send(32'b11, 2, "gap_tail");

    // Reset mid-sequence discards the partial match
    send(32'b101, 3, "pre_rst");
    do_rst("mid_rst");
    send(32'b11011, 5, "post_rst");

    // Saturation of the counter
    do_cfg(4'b1111, 1'b1, "cfg_sat");
    send(32'hFFF, 12, "sat");

    // All-zero pattern must still wait for N bits
    do_cfg(4'b0000, 1'b0, "cfg_zero");
    send(32'b000000000, 9, "zeros");

    // Random stimulus with occasional reconfiguration and reset
    for (int i = 0; i < 800; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 2) do_rst("rand_rst");
      else if (r < 6) do_cfg(N'($urandom), 1'($urandom), "rand_cfg");
      else step(($urandom_range(0, 3) != 0), 1'($urandom), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
